// File: rtl/shift_delay_ctrl.sv
// Valid/ready controller wrapping a free-running fixed-latency delay line.
// A valid pipe tracks live slots, an output FIFO absorbs stalls, and credit throttles upstream.
module shift_delay_ctrl #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              flush,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [WIDTH-1:0]                  s_data,
    output logic [WIDTH-1:0]                  dl_din,
    input  logic [WIDTH-1:0]                  dl_dout,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [WIDTH-1:0]                  m_data,
    output logic                              busy,
    output logic                              drain_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] vp_q, vp_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  fcnt_q, fcnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic accept;
    logic pop;
    logic wr;

    // Credit counts words in the delay line plus the FIFO, so a FIFO write can never overflow.
    assign s_ready     = (state_q == StRun) && (cnt_q < FifoFull);
    assign accept      = s_valid && s_ready;
    assign m_valid     = (fcnt_q != '0);
    assign pop         = m_valid && m_ready;
    assign wr          = vp_q[DEPTH-1];
    assign m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
    assign dl_din      = s_data;
    assign busy        = (state_q != StIdle);
    assign drain_done  = (state_q == StDrain) && (cnt_q == '0);
    assign outstanding = cnt_q;

    always_comb begin
        state_d  = state_q;
        vp_d     = (vp_q << 1) | DEPTH'(accept);
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (flush || !en) state_d = StDrain;
            StDrain: if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        case ({wr, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vp_q     <= '0;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            vp_q     <= vp_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= dl_dout;
        end
    end

endmodule

// File: tb/tb_shift_delay_ctrl.sv
// Scoreboard bench for shift_delay_ctrl with a behavioural delay line attached.
module tb_shift_delay_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int FD    = 10;
    localparam int CW    = $clog2(FD + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] dl_din;
    logic [WIDTH-1:0] dl_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             busy;
    logic             drain_done;
    logic [CW-1:0]    outstanding;

    shift_delay_ctrl #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .dl_din      (dl_din),
        .dl_dout     (dl_dout),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .drain_done  (drain_done),
        .outstanding (outstanding)
    );

    // Free-running delay line with no reset, as in the real datapath.
    logic [WIDTH-1:0] dl_pipe [DEPTH];
    always @(posedge clk) begin
        dl_pipe[0] <= dl_din;
        for (int i = 1; i < DEPTH; i++) dl_pipe[i] <= dl_pipe[i-1];
    end
    assign dl_dout = dl_pipe[DEPTH-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int pops = 0;
    logic [WIDTH-1:0] q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int k = 0;
        while ((q.size() != 0 || outstanding != '0) && k < bound) begin
            step();
            k++;
        end
        check(name, 32'((q.size() == 0) && (outstanding == '0)), 32'd1);
    endtask

    // Monitor: compare credit against the model, pop on handshake, then record new transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            check("outstanding_model", 32'(outstanding), 32'(q.size()));
            check("dl_din_passthru", 32'(dl_din), 32'(s_data));
            if (!m_valid) check("m_data_idle_zero", 32'(m_data), 32'd0);
            if (m_valid && m_ready) begin
                pops++;
                if (q.size() == 0) begin
                    check("pop_without_expected_word", 32'(m_data), 32'hdead_beef);
                end else begin
                    check("m_data_order", 32'(m_data), 32'(q.pop_front()));
                end
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                acc_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int first;
    int acc0;
    int pulses;
    int pops0;
    logic [31:0] mv_hist;
    logic ready_ok;

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) step();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_no_en_ready", 32'(s_ready), 32'd0);

        // Single word: m_valid rises DEPTH+1 cycles after the accept cycle, for one cycle.
        en = 1'b1; m_ready = 1'b1;
        step();
        check("run_s_ready", 32'(s_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        s_valid = 1'b1; s_data = 16'hA5A5;
        first = -1; mv_hist = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mv_hist[k] = m_valid;
            if (m_valid && first < 0) first = k;
            step();
            if (k == 0) s_valid = 1'b0;
        end
        check("single_latency", 32'(first), 32'd9);
        check("single_width", 32'(mv_hist), 32'h0000_0200);

        // Full-rate stream; credit must never throttle.
        ready_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            if (!s_ready) ready_ok = 1'b0;
            step();
        end
        s_valid = 1'b0;
        check("stream_s_ready_held", 32'(ready_ok), 32'd1);
        wait_drain(10, "stream_drained");

        // Downstream stall: exactly FD words accepted, credit returns one cycle after first pop.
        m_ready = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h0200 + i);
            step();
        end
        s_valid = 1'b0;
        check("stall_accept_count", 32'(acc_cnt - acc0), 32'd10);
        check("stall_s_ready_low", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        check("stall_pop_cycle_ready", 32'(s_ready), 32'd0);
        step();
        check("stall_credit_return", 32'(s_ready), 32'd1);
        wait_drain(20, "stall_drained");

        // Flush with five words in flight.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h0300 + i);
            step();
        end
        s_valid = 1'b0; flush = 1'b1; en = 1'b0;
        step();
        flush = 1'b0;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_outstanding", 32'(outstanding), 32'd5);
        pulses = 0;
        for (int k = 0; k < 30 && busy; k++) begin
            if (drain_done) begin
                pulses++;
                check("drain_done_at_zero", 32'(outstanding), 32'd0);
            end
            step();
        end
        check("drain_done_pulses", 32'(pulses), 32'd1);
        check("drain_idle_busy", 32'(busy), 32'd0);
        check("drain_idle_pulse_low", 32'(drain_done), 32'd0);
        check("drain_queue_empty", 32'(q.size()), 32'd0);

        // Reset with 3 words in the FIFO and 4 in the delay line.
        en = 1'b1; m_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h0500 + i);
            step();
        end
        s_valid = 1'b0;
        repeat (9) step();
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h0600 + i);
            step();
        end
        s_valid = 1'b0;
        check("pre_rst_outstanding", 32'(outstanding), 32'd7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_outstanding", 32'(outstanding), 32'd0);
        q.delete();
        step();
        rst_n = 1'b1; m_ready = 1'b1;
        pops0 = pops;
        repeat (25) step();
        check("no_stale_pops", 32'(pops - pops0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        wait_drain(40, "random_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
